// File: rtl/param_reg_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
// The clear-engine state enum lives here so the top and the bench agree on it.
package param_reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/param_reg_file_pend_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set by a claim and
// cleared by the matching write, with a bulk flush when a clear starts.
module pend_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_pending,
    output logic              rt_pending
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_next;
    logic             set_ok;

    assign set_ok = set_en && !(ZERO_REG && (set_addr == '0));

    // NOTE: pend_next starts as a copy of pend so every path assigns it and no latch is inferred.
    always_comb begin
        pend_next = pend;
        if (flush) begin
            pend_next = '0;
        end else begin
            if (clr_en) pend_next[clr_addr] = 1'b0;
            // Applied after the clear so a same-cycle claim wins.
            if (set_ok) pend_next[set_addr] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_next;
    end

    assign rs_pending = pend[rs_addr];
    assign rt_pending = pend[rt_addr];

endmodule

// File: rtl/param_reg_file.sv
// Two-read/one-write register file with write bypass, optional hard-wired
// zero register, a pending scoreboard and a sequential clear engine.
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              rs_pending,
    output logic              rt_pending
);

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cidx, cidx_next;
    logic [DATA_W-1:0] regs [NREGS];

    logic wr_ok;
    logic rs_zero, rt_zero;
    logic pend_rs, pend_rt;

    assign busy    = (state == CLEAR);
    assign rs_zero = ZERO_REG && (rs_addr == '0);
    assign rt_zero = ZERO_REG && (rt_addr == '0);
    assign wr_ok   = !busy && wr_en && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        state_next = state;
        cidx_next  = cidx;
        case (state)
            CLEAR: begin
                cidx_next = cidx + 1'b1;
                if (cidx == LAST_IDX) state_next = IDLE;
            end
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cidx_next  = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cidx  <= '0;
        end else begin
            state <= state_next;
            cidx  <= cidx_next;
        end
    end

    // NOTE: the array has no reset; the clear engine is its only initialiser.
    always_ff @(posedge clk) begin
        if (busy)       regs[cidx]    <= '0;
        else if (wr_ok) regs[wr_addr] <= wr_data;
    end

    always_comb begin
        rs_data = '0;
        if (!busy && !rs_zero)
            rs_data = (wr_en && (wr_addr == rs_addr)) ? wr_data : regs[rs_addr];
    end

    always_comb begin
        rt_data = '0;
        if (!busy && !rt_zero)
            rt_data = (wr_en && (wr_addr == rt_addr)) ? wr_data : regs[rt_addr];
    end

    pend_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_pend (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      ((state == IDLE) && clr_req),
        .set_en     (claim_en && !busy),
        .set_addr   (claim_addr),
        .clr_en     (wr_en && !busy),
        .clr_addr   (wr_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_pending (pend_rs),
        .rt_pending (pend_rt)
    );

    assign rs_pending = pend_rs && !busy;
    assign rt_pending = pend_rt && !busy;

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; NREGS = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- clr_req, in, 1, request a full sequential clear.
- busy, out, 1, clear engine active.
- rs_addr, in, ADDR_W, read port A address.
- rt_addr, in, ADDR_W, read port B address.
- rs_data, out, DATA_W, read port A data.
- rt_data, out, DATA_W, read port B data.
- wr_en, in, 1, write strobe.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- claim_en, in, 1, mark claim_addr as pending (an in-flight producer).
- claim_addr, in, ADDR_W, register to mark pending.
- rs_pending, out, 1, pending bit of rs_addr.
- rt_pending, out, 1, pending bit of rt_addr.

Function
REQ-003 The FSM SHALL have two states, CLEAR and IDLE, with a clear index cidx of width ADDR_W.
REQ-004 In CLEAR, each cycle SHALL write 0 to reg[cidx] and increment cidx.
REQ-005 On the cycle cidx = NREGS-1 is written, the FSM SHALL go to IDLE; a clear therefore lasts exactly NREGS cycles.
REQ-006 In IDLE, clr_req=1 SHALL enter CLEAR with cidx=0 on the next edge.
REQ-007 clr_req in CLEAR SHALL be ignored; the clear does not restart.
REQ-008 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-009 While busy=1, rs_data and rt_data SHALL be 0, rs_pending and rt_pending SHALL be 0, and wr_en and claim_en SHALL be ignored.
REQ-010 In IDLE, wr_en=1 with a writable wr_addr SHALL update reg[wr_addr] at the edge; the new value is visible from the array in the following cycle.
REQ-011 Same-cycle bypass: if wr_en=1, wr_addr=rs_addr and the address is writable, rs_data SHALL equal wr_data combinationally; the same rule applies to rt.
REQ-012 With ZERO_REG=1, address 0 SHALL read 0 (bypass included), writes to it SHALL be dropped, and it SHALL never become pending.
REQ-013 Pending bits: claim_en=1 SHALL set pend[claim_addr]; wr_en=1 SHALL clear pend[wr_addr].
REQ-014 If claim and write target the same address in the same cycle, the pending bit SHALL end set (claim wins).
REQ-015 rs_pending/rt_pending SHALL be combinational from pend[] and SHALL NOT be bypassed by a same-cycle write.
REQ-016 Entering CLEAR SHALL zero all pending bits at that edge.
REQ-017 All read paths SHALL be combinational, with zero-cycle latency.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state=CLEAR, cidx=0 and pend=0; busy=1 while rst_n=0.
REQ-019 After rst_n rises, the clear SHALL run NREGS cycles, then busy=0.
REQ-020 Reset asserted mid-clear SHALL restart the clear from cidx=0.
REQ-021 The register array itself is not reset; it is initialised only by the clear engine.

Structure
REQ-022 The shared package SHALL hold the state enum (CLEAR, IDLE) and the default DATA_W/ADDR_W constants.
REQ-023 A sub-module pend_scoreboard SHALL hold the NREGS pending bits with the set/clear/priority logic of REQ-013, REQ-014 and REQ-016.
REQ-024 The array and clear FSM SHALL live in the top level.

Verification (defaults: DATA_W=32, ADDR_W=5)
REQ-025 Reset released -> busy=1 for exactly 32 cycles, then 0; every rs_addr reads 0x0.
REQ-026 In IDLE: write reg5=0xDEADBEEF with rs_addr=5 in the same cycle -> rs_data=0xDEADBEEF that cycle and the next.
REQ-027 Write reg0=0x1234, then read 0 -> 0x0; claim reg0 -> rs_pending=0.
REQ-028 Claim reg7 -> rt_pending=1 next cycle; write reg7 together with a claim of reg7 -> stays 1; write reg7 alone -> 0 next cycle.
REQ-029 Fill reg1..reg31 with nonzero values, pulse clr_req -> busy=1 for 32 cycles; writes issued during busy are dropped; afterwards all reads return 0x0.
REQ-030 Assert rst_n=0 at cidx=10 -> busy stays 1 and the clear restarts, finishing 32 cycles after release.
